// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Writeback arbiter and register scoreboard for a small in-order core.
//
// Three writeback sources share one register-file write port. The round-robin
// pointer picks the first valid source at or after it. The winner's address
// and data are registered and appear on the register-file port one cycle
// later. A scoreboard holds one busy bit per architectural register. Issue
// sets the bit and the matching writeback clears it. hazard_o reports when a
// source operand still has a write in flight.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         asynchronous active-low reset
//   req_valid_i    per-requester writeback valid (0=ALU, 1=load, 2=mul/div/CSR)
//   req_addr_i     destination register, requester k at [5k+4:5k]
//   req_data_i     write data, requester k at [32k+31:32k]
//   req_ready_o    one-hot grant, combinational
//   rf_wr_o        registered register-file write enable
//   rf_rd_addr_o   registered write address (holds when rf_wr_o=0)
//   rf_rd_o        registered write data    (holds when rf_wr_o=0)
//   issue_valid_i  an instruction with a destination is issued this cycle
//   issue_rd_i     destination register of the issued instruction
//   rs1_addr_i     first source register to check
//   rs2_addr_i     second source register to check
//   hazard_o       a source register has a pending write
//   busy_o         scoreboard, one bit per architectural register
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int NREQ = 3  // number of writeback requesters, fixed at 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [5*NREQ-1:0]    req_addr_i,
  input  logic [32*NREQ-1:0]   req_data_i,
  output logic [NREQ-1:0]      req_ready_o,

  output logic                 rf_wr_o,
  output logic [4:0]           rf_rd_addr_o,
  output logic [31:0]          rf_rd_o,

  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_rd_i,
  input  logic [4:0]           rs1_addr_i,
  input  logic [4:0]           rs2_addr_i,
  output logic                 hazard_o,
  output logic [31:0]          busy_o
);

  // Round-robin pointer: index of the requester with highest priority.
  logic [1:0]  ptr_q;
  logic [1:0]  ptr_d;

  // Scoreboard.
  logic [31:0] busy_q;
  logic [31:0] busy_d;

  // Arbitration result.
  logic [NREQ-1:0] grant;
  logic [1:0]      slot;
  logic            transfer;
  logic [4:0]      sel_addr;
  logic [31:0]     sel_data;
  logic            write_en;

  // Successor of a requester index, wrapping at NREQ.
  function automatic logic [1:0] next_slot(input logic [1:0] s);
    return (s == 2'(NREQ - 1)) ? 2'd0 : s + 2'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Grant: walk the requesters starting at the pointer and take the first
  // valid one. The walk is unrolled, so this is a small priority mux.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first; a path that leaves one unassigned infers a latch.
    grant = '0;
    slot  = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == '0 && req_valid_i[slot]) begin
        grant[slot] = 1'b1;
      end
      slot = next_slot(slot);
    end
  end

  assign req_ready_o = grant;
  assign transfer    = |grant;

  // Steer the winner's address and data, and compute the next pointer.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    ptr_d    = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_addr = req_addr_i[5*k +: 5];
        sel_data = req_data_i[32*k +: 32];
        ptr_d    = next_slot(2'(k));
      end
    end
  end

  // x0 is hardwired: the transfer is accepted but never reaches the file.
  assign write_en = transfer && (sel_addr != 5'd0);

  // ---------------------------------------------------------------------------
  // Scoreboard update. The clear is applied before the set, so an issue to
  // the register being written back in the same cycle leaves it busy: the
  // newer instruction still owes a result.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (write_en) begin
      busy_d[sel_addr] = 1'b0;
    end
    if (issue_valid_i && issue_rd_i != 5'd0) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Checked against registered state only; a writeback arriving this cycle
  // does not hide the hazard until it has been registered.
  assign hazard_o = ((rs1_addr_i != 5'd0) && busy_q[rs1_addr_i]) ||
                    ((rs2_addr_i != 5'd0) && busy_q[rs2_addr_i]);

  assign busy_o = busy_q;

  // ---------------------------------------------------------------------------
  // State registers. Reset also clears the write port, so a transfer captured
  // just before reset never produces a write after release.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) begin
      ptr_q        <= 2'd0;
      busy_q       <= '0;
      rf_wr_o      <= 1'b0;
      rf_rd_addr_o <= '0;
      rf_rd_o      <= '0;
    end else begin
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      rf_wr_o <= write_en;
      if (write_en) begin
        rf_rd_addr_o <= sel_addr;
        rf_rd_o      <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Self-checking bench for wb_arbiter. A behavioural model tracks the pointer,
// scoreboard and register-file port from the arbitration rules. A compare
// process checks every DUT output against the model at each falling edge.
// Directed sequences add hand-computed literal checks.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// falling edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [2:0]   req_valid_i;
  logic [14:0]  req_addr_i;
  logic [95:0]  req_data_i;
  logic [2:0]   req_ready_o;
  logic         rf_wr_o;
  logic [4:0]   rf_rd_addr_o;
  logic [31:0]  rf_rd_o;
  logic         issue_valid_i;
  logic [4:0]   issue_rd_i;
  logic [4:0]   rs1_addr_i;
  logic [4:0]   rs2_addr_i;
  logic         hazard_o;
  logic [31:0]  busy_o;

  int n_vec = 0;
  int n_err = 0;

  wb_arbiter #(.NREQ(3)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_addr_i    (req_addr_i),
    .req_data_i    (req_data_i),
    .req_ready_o   (req_ready_o),
    .rf_wr_o       (rf_wr_o),
    .rf_rd_addr_o  (rf_rd_addr_o),
    .rf_rd_o       (rf_rd_o),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .hazard_o      (hazard_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int          m_ptr;
  logic [31:0] m_busy;
  logic        m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [2:0]  pend;
  logic [14:0] pend_addr;
  logic [95:0] pend_data;

  // Rule: first valid requester in the order ptr, ptr+1, ptr+2 (mod 3).
  function automatic logic [2:0] pick(input logic [2:0] v, input int p);
    for (int i = 0; i < 3; i++) begin
      int k;
      k = (p + i) % 3;
      if (v[k]) return 3'(1 << k);
    end
    return 3'b000;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_ptr  = 0;
      m_busy = '0;
      m_wr   = 1'b0;
      m_addr = '0;
      m_data = '0;
      pend   = '0;
    end else begin
      logic [2:0] g;
      // A requester left waiting must present the same request again.
      for (int k = 0; k < 3; k++) begin
        if (pend[k]) begin
          check("hold_valid", 32'(req_valid_i[k]), 32'd1);
          check("hold_addr", 32'(req_addr_i[5*k +: 5]), 32'(pend_addr[5*k +: 5]));
          check("hold_data", req_data_i[32*k +: 32], pend_data[32*k +: 32]);
        end
      end
      g    = pick(req_valid_i, m_ptr);
      m_wr = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (g[k]) begin
          logic [4:0] a;
          a     = req_addr_i[5*k +: 5];
          m_ptr = (k + 1) % 3;
          if (a != 5'd0) begin
            m_wr      = 1'b1;
            m_addr    = a;
            m_data    = req_data_i[32*k +: 32];
            m_busy[a] = 1'b0;
          end
        end
      end
      if (issue_valid_i && issue_rd_i != 5'd0) m_busy[issue_rd_i] = 1'b1;
      pend      = req_valid_i & ~g;
      pend_addr = req_addr_i;
      pend_data = req_data_i;
    end
  end

  // Compare process: every falling edge, every output.
  always @(negedge clk_i) begin
    logic exp_haz;
    exp_haz = (rs1_addr_i != 5'd0 && m_busy[rs1_addr_i]) ||
              (rs2_addr_i != 5'd0 && m_busy[rs2_addr_i]);
    check("ready", 32'(req_ready_o), 32'(pick(req_valid_i, m_ptr)));
    check("rf_wr", 32'(rf_wr_o), 32'(m_wr));
    check("rf_addr", 32'(rf_rd_addr_o), 32'(m_addr));
    check("rf_data", rf_rd_o, m_data);
    check("busy", busy_o, m_busy);
    check("hazard", 32'(hazard_o), 32'(exp_haz));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  logic [2:0] granted;

  task automatic mid();
    @(negedge clk_i);
  endtask

  // Finish the cycle: note grants, pass the edge, retire granted requests.
  task automatic fin();
    granted = req_valid_i & req_ready_o;
    @(posedge clk_i);
    #1;
    req_valid_i   = req_valid_i & ~granted;
    issue_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 6 && req_valid_i != 3'b000; n++) begin
      mid();
      fin();
    end
    check(name, 32'(req_valid_i), 32'd0);
  endtask

  logic [2:0] pats [4];

  initial begin
    rst_ni        = 1'b0;
    req_valid_i   = '0;
    req_addr_i    = '0;
    req_data_i    = '0;
    issue_valid_i = 1'b0;
    issue_rd_i    = '0;
    rs1_addr_i    = '0;
    rs2_addr_i    = '0;
    pats = '{3'b101, 3'b110, 3'b011, 3'b111};

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_wr", 32'(rf_wr_o), 32'd0);
    check("rst_addr", 32'(rf_rd_addr_o), 32'd0);
    check("rst_busy", busy_o, 32'd0);
    rst_ni = 1'b1;

    // All three requesters, addrs 1,2,3: grants 0,1,2; writes one cycle later.
    req_addr_i  = {5'd3, 5'd2, 5'd1};
    req_data_i  = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    req_valid_i = 3'b111;
    mid(); check("rr_g0", 32'(req_ready_o), 32'b001); check("rr_wr0", 32'(rf_wr_o), 32'd0); fin();
    mid(); check("rr_g1", 32'(req_ready_o), 32'b010); check("rr_a1", 32'(rf_rd_addr_o), 32'd1); fin();
    mid(); check("rr_g2", 32'(req_ready_o), 32'b100); check("rr_a2", 32'(rf_rd_addr_o), 32'd2); fin();
    mid(); check("rr_wr3", 32'(rf_wr_o), 32'd1); check("rr_a3", 32'(rf_rd_addr_o), 32'd3);
    check("rr_d3", rf_rd_o, 32'h3333_0003); fin();
    mid(); check("rr_idle", 32'(rf_wr_o), 32'd0); fin();

    // Issue x5, then ALU writeback to x5 two cycles later.
    issue_valid_i = 1'b1; issue_rd_i = 5'd5;
    mid(); fin();
    rs1_addr_i = 5'd5;
    mid(); check("sb_busy5", 32'(busy_o[5]), 32'd1); check("sb_haz", 32'(hazard_o), 32'd1); fin();
    req_addr_i[4:0] = 5'd5; req_data_i[31:0] = 32'hDEAD_BEEF; req_valid_i = 3'b001;
    mid(); check("sb_g", 32'(req_ready_o), 32'b001); check("sb_nobypass", 32'(hazard_o), 32'd1); fin();
    mid(); check("sb_wr", 32'(rf_wr_o), 32'd1); check("sb_addr", 32'(rf_rd_addr_o), 32'd5);
    check("sb_data", rf_rd_o, 32'hDEAD_BEEF); check("sb_clr", 32'(busy_o[5]), 32'd0);
    check("sb_haz0", 32'(hazard_o), 32'd0); fin();

    // Load writeback to x0: accepted, no write, scoreboard untouched.
    issue_valid_i = 1'b1; issue_rd_i = 5'd9;
    mid(); fin();
    req_addr_i[9:5] = 5'd0; req_data_i[63:32] = 32'hCAFE_F00D; req_valid_i = 3'b010;
    mid(); check("x0_g", 32'(req_ready_o), 32'b010); fin();
    mid(); check("x0_wr", 32'(rf_wr_o), 32'd0); check("x0_addr", 32'(rf_rd_addr_o), 32'd5);
    check("x0_data", rf_rd_o, 32'hDEAD_BEEF); check("x0_busy", busy_o, 32'h0000_0200); fin();

    // Issue x7 in the same cycle as a writeback to x7: stays busy.
    issue_valid_i = 1'b1; issue_rd_i = 5'd7;
    mid(); fin();
    issue_valid_i = 1'b1; issue_rd_i = 5'd7;
    req_addr_i[14:10] = 5'd7; req_data_i[95:64] = 32'h0000_0777; req_valid_i = 3'b100;
    mid(); check("same_g", 32'(req_ready_o), 32'b100); fin();
    mid(); check("same_busy7", 32'(busy_o[7]), 32'd1); check("same_wr", 32'(rf_wr_o), 32'd1); fin();

    // No counting: re-issue to busy x7, then one writeback clears it.
    issue_valid_i = 1'b1; issue_rd_i = 5'd7;
    mid(); fin();
    req_addr_i[4:0] = 5'd7; req_data_i[31:0] = 32'h0000_0007; req_valid_i = 3'b001;
    mid(); fin();
    mid(); check("nocount", 32'(busy_o[7]), 32'd0); fin();

    // Issue to x0 has no effect.
    issue_valid_i = 1'b1; issue_rd_i = 5'd0;
    mid(); fin();
    mid(); check("iss_x0", busy_o, 32'h0000_0200); fin();

    // Contention patterns; the compare process checks every cycle.
    for (int r = 16; r <= 18; r++) begin
      issue_valid_i = 1'b1; issue_rd_i = 5'(r);
      mid(); fin();
    end
    mid(); check("busy_set", busy_o, 32'h0007_0200); fin();
    rs1_addr_i = 5'd16; rs2_addr_i = 5'd18;
    for (int p = 0; p < 4; p++) begin
      req_addr_i  = {5'(18 - p), 5'(17 + p), (p == 2) ? 5'd0 : 5'(16 + p)};
      req_data_i  = {32'(32'hA000_0000 + p), 32'(32'hB000_0000 + p), 32'(32'hC000_0000 + p)};
      req_valid_i = pats[p];
      if (p == 1) begin issue_valid_i = 1'b1; issue_rd_i = 5'd18; end
      drain("drain");
    end

    // Reset while a transfer is registered.
    req_addr_i[4:0] = 5'd12; req_data_i[31:0] = 32'h1212_1212; req_valid_i = 3'b001;
    mid(); fin();
    #1;
    rst_ni = 1'b0;
    #1;
    check("mrst_wr", 32'(rf_wr_o), 32'd0);
    check("mrst_addr", 32'(rf_rd_addr_o), 32'd0);
    check("mrst_data", rf_rd_o, 32'd0);
    check("mrst_busy", busy_o, 32'd0);
    mid(); fin();
    rst_ni = 1'b1;
    req_addr_i  = {5'd22, 5'd21, 5'd20};
    req_data_i  = {32'h2200_0022, 32'h2100_0021, 32'h2000_0020};
    req_valid_i = 3'b011;
    mid(); check("post_ptr0", 32'(req_ready_o), 32'b001); check("post_nowr", 32'(rf_wr_o), 32'd0); fin();
    mid(); check("post_wr", 32'(rf_wr_o), 32'd1); check("post_addr", 32'(rf_rd_addr_o), 32'd20); fin();
    drain("drain_post");
    mid(); fin();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
